// File: rtl/reg_read_stage_if.sv
// Decode-to-execute register-read stage bundle: decoded instruction in, register-file
// read port, writeback bypass, execute handshake, and registered instruction out.
interface reg_read_stage_if #(
  parameter int OP_W = 32
);
  logic            decValid;
  logic [31:0]     decPc;
  logic [31:0]     decInsn;
  logic [63:0]     decOpId;
  logic [OP_W-1:0] decOp;
  logic            decRegWrite;
  logic [11:0]     decCsrAddr;
  logic [4:0]      decSrcRegAddr1;
  logic [4:0]      decSrcRegAddr2;
  logic [4:0]      decDstRegAddr;
  logic            decTrapValid;
  logic [3:0]      decTrapCause;
  logic            stallOut;

  logic [4:0]      rfAddr1;
  logic [4:0]      rfAddr2;
  logic [31:0]     rfData1;
  logic [31:0]     rfData2;

  logic            wbValid;
  logic [4:0]      wbRegAddr;
  logic [31:0]     wbData;

  logic            exReady;
  logic            flush;

  logic            rrValid;
  logic [31:0]     rrPc;
  logic [31:0]     rrInsn;
  logic [63:0]     rrOpId;
  logic [OP_W-1:0] rrOp;
  logic [11:0]     rrCsrAddr;
  logic [4:0]      rrDstRegAddr;
  logic            rrRegWrite;
  logic            rrTrapValid;
  logic [3:0]      rrTrapCause;
  logic [31:0]     rrSrcData1;
  logic [31:0]     rrSrcData2;
  logic [31:0]     stallCount;

  modport master (
    output decValid, decPc, decInsn, decOpId, decOp, decRegWrite, decCsrAddr,
           decSrcRegAddr1, decSrcRegAddr2, decDstRegAddr, decTrapValid, decTrapCause,
           rfData1, rfData2, wbValid, wbRegAddr, wbData, exReady, flush,
    input  stallOut, rfAddr1, rfAddr2, rrValid, rrPc, rrInsn, rrOpId, rrOp, rrCsrAddr,
           rrDstRegAddr, rrRegWrite, rrTrapValid, rrTrapCause, rrSrcData1, rrSrcData2,
           stallCount
  );

  modport slave (
    input  decValid, decPc, decInsn, decOpId, decOp, decRegWrite, decCsrAddr,
           decSrcRegAddr1, decSrcRegAddr2, decDstRegAddr, decTrapValid, decTrapCause,
           rfData1, rfData2, wbValid, wbRegAddr, wbData, exReady, flush,
    output stallOut, rfAddr1, rfAddr2, rrValid, rrPc, rrInsn, rrOpId, rrOp, rrCsrAddr,
           rrDstRegAddr, rrRegWrite, rrTrapValid, rrTrapCause, rrSrcData1, rrSrcData2,
           stallCount
  );
endinterface

// File: rtl/reg_read_stage.sv
// Register-read stage: scoreboarded RAW hazard detection, writeback bypass of operands,
// and a single holding register toward execute with backpressure and flush.
module reg_read_stage #(
  parameter int OP_W = 32
) (
  input logic              clk,
  input logic              rst,
  reg_read_stage_if.slave  io
);

  logic [31:0]     busy;
  logic [31:0]     busy_next;
  logic            hazard1;
  logic            hazard2;
  logic            stall;
  logic            accept;
  logic            flush_drop;
  logic [31:0]     opnd1;
  logic [31:0]     opnd2;
  logic [OP_W-1:0] op_in;

  // A pending writer blocks a read unless its value is arriving on writeback this cycle.
  function automatic logic raw_hazard(input logic [4:0] src, input logic [31:0] bsy,
                                      input logic wb_v, input logic [4:0] wb_a);
    return (src != 5'd0) && bsy[src] && !(wb_v && (wb_a == src));
  endfunction

  function automatic logic [31:0] sel_operand(input logic [4:0] src, input logic [31:0] rf,
                                              input logic wb_v, input logic [4:0] wb_a,
                                              input logic [31:0] wb_d);
    if (src == 5'd0)
      return 32'd0;
    if (wb_v && (wb_a == src))
      return wb_d;
    return rf;
  endfunction

  assign io.rfAddr1 = io.decSrcRegAddr1;
  assign io.rfAddr2 = io.decSrcRegAddr2;
  assign op_in      = io.decOp;

  always_comb begin
    hazard1 = io.decValid && !io.decTrapValid &&
              raw_hazard(io.decSrcRegAddr1, busy, io.wbValid, io.wbRegAddr);
    hazard2 = io.decValid && !io.decTrapValid &&
              raw_hazard(io.decSrcRegAddr2, busy, io.wbValid, io.wbRegAddr);
    stall   = io.decValid && !io.flush &&
              (hazard1 || hazard2 || (io.rrValid && !io.exReady));
    accept  = io.decValid && !io.flush && !stall;
    opnd1   = sel_operand(io.decSrcRegAddr1, io.rfData1, io.wbValid, io.wbRegAddr, io.wbData);
    opnd2   = sel_operand(io.decSrcRegAddr2, io.rfData2, io.wbValid, io.wbRegAddr, io.wbData);
  end

  assign io.stallOut = stall;

  // A flushed writer that execute never took will never write back, so release its bit.
  assign flush_drop = io.flush && io.rrValid && io.rrRegWrite && !io.exReady;

  always_comb begin
    busy_next = busy;
    if (io.wbValid)
      busy_next[io.wbRegAddr] = 1'b0;
    if (flush_drop)
      busy_next[io.rrDstRegAddr] = 1'b0;
    if (accept && io.decRegWrite && !io.decTrapValid && (io.decDstRegAddr != 5'd0))
      busy_next[io.decDstRegAddr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Stage boundary: decode -> execute holding register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      io.rrValid     <= 1'b0;
      busy           <= 32'd0;
      io.stallCount  <= 32'd0;
      io.rrPc        <= 32'd0;
      io.rrInsn      <= 32'd0;
      io.rrOpId      <= 64'd0;
      io.rrOp        <= '0;
      io.rrCsrAddr   <= 12'd0;
      io.rrDstRegAddr <= 5'd0;
      io.rrRegWrite  <= 1'b0;
      io.rrTrapValid <= 1'b0;
      io.rrTrapCause <= 4'd0;
      io.rrSrcData1  <= 32'd0;
      io.rrSrcData2  <= 32'd0;
    end else begin
      busy <= busy_next;
      if (stall)
        io.stallCount <= io.stallCount + 32'd1;
      if (io.flush)
        io.rrValid <= 1'b0;
      else if (accept)
        io.rrValid <= 1'b1;
      else if (io.exReady)
        io.rrValid <= 1'b0;
      if (accept) begin
        io.rrPc         <= io.decPc;
        io.rrInsn       <= io.decInsn;
        io.rrOpId       <= io.decOpId;
        io.rrOp         <= op_in;
        io.rrCsrAddr    <= io.decCsrAddr;
        io.rrDstRegAddr <= io.decDstRegAddr;
        io.rrRegWrite   <= io.decRegWrite;
        io.rrTrapValid  <= io.decTrapValid;
        io.rrTrapCause  <= io.decTrapCause;
        io.rrSrcData1   <= opnd1;
        io.rrSrcData2   <= opnd2;
      end
    end
  end

endmodule
